// File: rtl/fill_valve_arbiter.sv
// -----------------------------------------------------------------------------
// fill_valve_arbiter
//
// Shares one water-fill valve among NUM_BAYS washing-machine bays. A bay's
// request is granted in round-robin order; the valve is then held open for a
// latched number of active (unpaused) cycles. A one-cycle fill_done pulse on
// the owner's bit tells the bay controller that its fill is complete.
//
// Parameters
//   NUM_BAYS : number of requesting bays (2..8)
//   LEN_W    : width of the fill-length counter
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req        in   [NUM_BAYS] level request per bay
//   fill_len   in   [LEN_W] fill duration in active cycles, sampled on grant
//   time_pause in   freezes the fill counter; valve stays open
//   grant      out  [NUM_BAYS] one-hot current owner, zero when idle
//   valve_open out  valve drive, high only while filling
//   fill_done  out  [NUM_BAYS] one-cycle pulse on the finished bay's bit
//   busy       out  high while filling or signalling completion
//
// Build option
//   FILL_ABORT_EN : when defined, an owner dropping its request during the
//                   fill aborts it (no fill_done). When undefined, requests
//                   are ignored during the fill and it always completes.
// -----------------------------------------------------------------------------
module fill_valve_arbiter #(
    parameter int NUM_BAYS = 4,
    parameter int LEN_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_BAYS-1:0] req,
    input  logic [LEN_W-1:0]    fill_len,
    input  logic                time_pause,
    output logic [NUM_BAYS-1:0] grant,
    output logic                valve_open,
    output logic [NUM_BAYS-1:0] fill_done,
    output logic                busy
);

    localparam int IDX_W = (NUM_BAYS > 1) ? $clog2(NUM_BAYS) : 1;

    localparam logic [LEN_W-1:0]    LEN_ZERO   = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]    LEN_ONE    = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [NUM_BAYS-1:0] BAYS_ZERO  = {NUM_BAYS{1'b0}};
    localparam logic [NUM_BAYS-1:0] BAYS_ONE   = {{(NUM_BAYS-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]    LAST_RESET = IDX_W'(NUM_BAYS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [LEN_W-1:0]  cnt_r;
    logic [IDX_W-1:0]  last_r;

    logic              found_s;
    logic [IDX_W-1:0]  win_s;

    // Round-robin pick: scan from the bay after the previous winner, wrapping.
    always_comb begin
        found_s = 1'b0;
        win_s   = {IDX_W{1'b0}};
        for (int i = 1; i <= NUM_BAYS; i++) begin
            if (!found_s && req[(int'(last_r) + i) % NUM_BAYS]) begin
                found_s = 1'b1;
                win_s   = IDX_W'((int'(last_r) + i) % NUM_BAYS);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Arbiter FSM with registered outputs and the fill counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= LEN_ZERO;
            last_r     <= LAST_RESET;
            grant      <= BAYS_ZERO;
            valve_open <= 1'b0;
            fill_done  <= BAYS_ZERO;
            busy       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    fill_done <= BAYS_ZERO;
                    if (found_s) begin
                        grant      <= BAYS_ONE << win_s;
                        last_r     <= win_s;
                        // A zero length still opens the valve for one cycle.
                        cnt_r      <= (fill_len == LEN_ZERO) ? LEN_ONE : fill_len;
                        valve_open <= 1'b1;
                        busy       <= 1'b1;
                        state_r    <= ST_FILL;
                    end else begin
                        grant      <= BAYS_ZERO;
                        valve_open <= 1'b0;
                        busy       <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                end

                ST_FILL: begin
                    fill_done <= BAYS_ZERO;
`ifdef FILL_ABORT_EN
                    if ((req & grant) == BAYS_ZERO) begin
                        // Owner withdrew: close without a completion pulse.
                        grant      <= BAYS_ZERO;
                        valve_open <= 1'b0;
                        busy       <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else
`endif
                    if (time_pause) begin
                        cnt_r   <= cnt_r;
                        state_r <= ST_FILL;
                    end else if (cnt_r == LEN_ONE) begin
                        // Counter stays at one; it is reloaded on the next grant.
                        fill_done  <= grant;
                        grant      <= BAYS_ZERO;
                        valve_open <= 1'b0;
                        busy       <= 1'b1;
                        state_r    <= ST_DONE;
                    end else begin
                        cnt_r   <= cnt_r - LEN_ONE;
                        state_r <= ST_FILL;
                    end
                end

                ST_DONE: begin
                    fill_done  <= BAYS_ZERO;
                    grant      <= BAYS_ZERO;
                    valve_open <= 1'b0;
                    busy       <= 1'b0;
                    state_r    <= ST_IDLE;
                end

                default: begin
                    fill_done  <= BAYS_ZERO;
                    grant      <= BAYS_ZERO;
                    valve_open <= 1'b0;
                    busy       <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fill_valve_arbiter.sv
module tb_fill_valve_arbiter;

    localparam int NB = 4;
    localparam int LW = 16;

    logic          clk;
    logic          rst_n;
    logic [NB-1:0] req;
    logic [LW-1:0] fill_len;
    logic          time_pause;
    logic [NB-1:0] grant;
    logic          valve_open;
    logic [NB-1:0] fill_done;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    fill_valve_arbiter #(.NUM_BAYS(NB), .LEN_W(LW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .fill_len   (fill_len),
        .time_pause (time_pause),
        .grant      (grant),
        .valve_open (valve_open),
        .fill_done  (fill_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    // Transaction-level view: who owns the valve, how many active cycles are
    // left, which bay just finished, and who won last.
    typedef struct {
        int owner;
        int left;
        int done_bay;
        int last;
    } mstate_t;

    localparam mstate_t M_RESET = '{owner: -1, left: 0, done_bay: -1, last: NB - 1};

    mstate_t m = M_RESET;

    function automatic mstate_t step(mstate_t s, logic [NB-1:0] r, logic [LW-1:0] fl, logic p);
        mstate_t n = s;
        if (s.done_bay >= 0) begin
            n.done_bay = -1;
        end else if (s.owner < 0) begin
            for (int i = 1; i <= NB; i++) begin
                if (n.owner < 0 && r[(s.last + i) % NB]) n.owner = (s.last + i) % NB;
            end
            if (n.owner >= 0) begin
                n.last = n.owner;
                n.left = (fl == 0) ? 1 : int'(fl);
            end
        end else begin
`ifdef FILL_ABORT_EN
            if (!r[s.owner]) begin
                n.owner = -1;
                return n;
            end
`endif
            if (!p) begin
                n.left = s.left - 1;
                if (n.left == 0) begin
                    n.done_bay = s.owner;
                    n.owner    = -1;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= M_RESET;
        else        m <= step(m, req, fill_len, time_pause);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every cycle, the DUT outputs must match the model.
    always @(negedge clk) begin
        chk("model_grant", 32'(grant), (m.owner >= 0) ? (32'd1 << m.owner) : 32'd0);
        chk("model_valve", 32'(valve_open), (m.owner >= 0) ? 32'd1 : 32'd0);
        chk("model_done", 32'(fill_done), (m.done_bay >= 0) ? (32'd1 << m.done_bay) : 32'd0);
        chk("model_busy", 32'(busy), (m.owner >= 0 || m.done_bay >= 0) ? 32'd1 : 32'd0);
    end

    // ------------------------------------------------------------ helpers
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Waits for the valve to open, reports the idle gap, owner, open length
    // and the fill_done value in the cycle right after the valve closes.
    task automatic measure(output int gap, output logic [NB-1:0] g,
                           output int vc, output logic [NB-1:0] d);
        gap = 0;
        vc  = 0;
        g   = '0;
        d   = '0;
        while (!valve_open && gap < 100) begin
            @(negedge clk);
            gap++;
        end
        if (!valve_open) begin
            chk("timeout_open", 32'd0, 32'd1);
        end else begin
            g = grant;
            while (valve_open && vc < 200) begin
                vc++;
                @(negedge clk);
            end
            d = fill_done;
        end
    endtask

    task automatic wait_open();
        int t = 0;
        while (!valve_open && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!valve_open) chk("timeout_open", 32'd0, 32'd1);
    endtask

    // ------------------------------------------------------------ stimulus
    logic [NB-1:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        int gap, vc;
        logic [NB-1:0] g, d;

        rst_n      = 1'b0;
        req        = 4'b0000;
        fill_len   = 16'd0;
        time_pause = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_valve", 32'(valve_open), 32'd0);
        chk("rst_done", 32'(fill_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Single request, length 5.
        req = 4'b0010; fill_len = 16'd5;
        measure(gap, g, vc, d);
        req = 4'b0000;
        chk("t1_latency", 32'(gap), 32'd1);
        chk("t1_grant", 32'(g), 32'h2);
        chk("t1_len", 32'(vc), 32'd5);
        chk("t1_done", 32'(d), 32'h2);
        @(negedge clk);
        chk("t1_done_1cyc", 32'(fill_done), 32'd0);
        chk("t1_busy_low", 32'(busy), 32'd0);

        // All bays requesting: round-robin from bay 0 with 2-cycle gaps.
        do_reset();
        req = 4'b1111; fill_len = 16'd3;
        for (int k = 0; k < 5; k++) begin
            measure(gap, g, vc, d);
            chk("t2_grant", 32'(g), 32'(exp_seq[k]));
            chk("t2_len", 32'(vc), 32'd3);
            chk("t2_done", 32'(d), 32'(exp_seq[k]));
            if (k > 0) chk("t2_gap", 32'(gap), 32'd2);
        end
        req = 4'b0000;

        // Pause held across three edges mid-fill: 4 + 3 open cycles.
        req = 4'b0100; fill_len = 16'd4;
        wait_open();
        vc = 0;
        while (valve_open && vc < 200) begin
            vc++;
            if (vc == 2) time_pause = 1'b1;
            if (vc == 5) time_pause = 1'b0;
            @(negedge clk);
        end
        req = 4'b0000;
        chk("t3_len", 32'(vc), 32'd7);
        chk("t3_done", 32'(fill_done), 32'h4);
        @(negedge clk);
        chk("t3_done_1cyc", 32'(fill_done), 32'd0);

        // Pause on the final counting edge extends the fill by one.
        req = 4'b0010; fill_len = 16'd2;
        wait_open();
        vc = 0;
        while (valve_open && vc < 200) begin
            vc++;
            if (vc == 2) time_pause = 1'b1;
            if (vc == 3) time_pause = 1'b0;
            @(negedge clk);
        end
        req = 4'b0000;
        chk("t4_len", 32'(vc), 32'd3);
        chk("t4_done", 32'(fill_done), 32'h2);

        // Zero length behaves as one.
        req = 4'b0001; fill_len = 16'd0;
        measure(gap, g, vc, d);
        req = 4'b0000;
        chk("t5_grant", 32'(g), 32'h1);
        chk("t5_len", 32'(vc), 32'd1);
        chk("t5_done", 32'(d), 32'h1);

        // Reset in the second cycle of a 10-cycle fill.
        @(negedge clk);
        req = 4'b0100; fill_len = 16'd10;
        wait_open();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valve_async", 32'(valve_open), 32'd0);
        chk("t6_grant_async", 32'(grant), 32'd0);
        chk("t6_done_async", 32'(fill_done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b1111; fill_len = 16'd2;
        measure(gap, g, vc, d);
        req = 4'b0000;
        chk("t6_grant_bay0", 32'(g), 32'h1);
        chk("t6_len", 32'(vc), 32'd2);

        // Bay 2 drops its request in cycle 3 while bay 3 is waiting.
        do_reset();
        req = 4'b0100; fill_len = 16'd8;
        wait_open();
        chk("t7_grant", 32'(grant), 32'h4);
        vc = 0;
        while (valve_open && vc < 200) begin
            vc++;
            if (vc == 3) req = 4'b1000;
            @(negedge clk);
        end
`ifdef FILL_ABORT_EN
        chk("t7_len_abort", 32'(vc), 32'd3);
        chk("t7_no_done", 32'(fill_done), 32'd0);
`else
        chk("t7_len_full", 32'(vc), 32'd8);
        chk("t7_done", 32'(fill_done), 32'h4);
`endif
        measure(gap, g, vc, d);
        req = 4'b0000;
        chk("t7_next_grant", 32'(g), 32'h8);
        chk("t7_next_len", 32'(vc), 32'd8);
        chk("t7_next_done", 32'(d), 32'h8);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
